// File: rtl/cubo_pkg.sv
// Shared definitions for the cube move executor.
// Contents: FSM state encoding, face codes (U,D,F,B,L,R), default face count
// and a helper that sizes the shared settle/timeout counter.
package cubo_pkg;

  localparam int N_FACES = 6;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CHECK  = 4'd1,
    ST_START  = 4'd2,
    ST_WAIT   = 4'd3,
    ST_SETTLE = 4'd4,
    ST_DONE   = 4'd5,
    ST_ERROR  = 4'd6
  } estado_t;

  localparam logic [2:0] FACE_U = 3'd0;
  localparam logic [2:0] FACE_D = 3'd1;
  localparam logic [2:0] FACE_F = 3'd2;
  localparam logic [2:0] FACE_B = 3'd3;
  localparam logic [2:0] FACE_L = 3'd4;
  localparam logic [2:0] FACE_R = 3'd5;

  // Width able to hold the larger of the two cycle counts.
  function automatic int cnt_width(input int settle, input int timeout);
    int m;
    m = (settle > timeout) ? settle : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/contador_timer.sv
// Shared cycle counter for the move executor.
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   zera_i        clear the count (has priority over conta_i)
//   conta_i       increment the count; holds at all-ones instead of wrapping
//   limit_i       compare value
//   fim_o         count equals limit_i
module contador_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera_i,
  input  logic         conta_i,
  input  logic [W-1:0] limit_i,
  output logic         fim_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (zera_i) begin
      count_d = '0;
    end else if (conta_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fim_o = (count_q == limit_i);

endmodule

// File: rtl/executor_movimentos.sv
// Cube move executor placed in front of the per-face servo_360 units.
// Takes one move (face + quarter turns), fires the face unit once per quarter
// turn, waits for its pronto, lets the mechanics settle, then pulses done.
// Invalid faces and missing pronto end in ERROR until clear_erro.
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   cmd_valid/face/turns    move command, sampled only when cmd_ready is high
//   cmd_ready               high only in IDLE
//   iniciar [N_FACES]       one-cycle one-hot start pulse to the face units
//   pronto  [N_FACES]       completion pulses from the face units
//   busy, done, erro        status (done is a one-cycle pulse)
//   clear_erro              leave ERROR
//   db_estado, db_turns_left debug views of state code and remaining turns
module executor_movimentos #(
  parameter int N_FACES        = cubo_pkg::N_FACES,
  parameter int SETTLE_CYCLES  = 5_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_face,
  input  logic [1:0]         cmd_turns,
  output logic               cmd_ready,
  output logic [N_FACES-1:0] iniciar,
  input  logic [N_FACES-1:0] pronto,
  output logic               busy,
  output logic               done,
  output logic               erro,
  input  logic               clear_erro,
  output logic [3:0]         db_estado,
  output logic [1:0]         db_turns_left
);

  import cubo_pkg::*;

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIM_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);

  estado_t      state_q, state_d;
  logic [2:0]   face_q, face_d;
  logic [1:0]   turns_q, turns_d;

  logic               zera, conta, fim;
  logic [CNT_W-1:0]   limit;
  logic [N_FACES-1:0] face_oh;
  logic               pronto_sel;

  // An out-of-range face shifts out to all zeros, so nothing is ever fired for it.
  assign face_oh    = N_FACES'(1) << face_q;
  assign pronto_sel = |(pronto & face_oh);

  // Only WAIT measures against the timeout; SETTLE (and idle states) use the settle limit.
  assign limit = (state_q == ST_WAIT) ? LIM_TIMEOUT : LIM_SETTLE;

  contador_timer #(
    .W (CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (zera),
    .conta_i (conta),
    .limit_i (limit),
    .fim_o   (fim)
  );

  always_comb begin
    state_d = state_q;
    face_d  = face_q;
    turns_d = turns_q;
    zera    = 1'b0;
    conta   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          face_d  = cmd_face;
          turns_d = cmd_turns;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (int'(face_q) >= N_FACES) begin
          state_d = ST_ERROR;
        end else if (turns_q == 2'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        zera    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        conta = 1'b1;
        // pronto is checked first so a reply on the last allowed cycle still counts.
        if (pronto_sel) begin
          zera    = 1'b1;
          turns_d = turns_q - 2'd1;
          state_d = ST_SETTLE;
        end else if (fim) begin
          state_d = ST_ERROR;
        end
      end
      ST_SETTLE: begin
        conta = 1'b1;
        if (fim) begin
          zera    = 1'b1;
          state_d = (turns_q != 2'd0) ? ST_START : ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (clear_erro) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      face_q  <= 3'd0;
      turns_q <= 2'd0;
    end else begin
      state_q <= state_d;
      face_q  <= face_d;
      turns_q <= turns_d;
    end
  end

  // Moore outputs, decoded from the registered state only.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    erro      = 1'b0;
    iniciar   = '0;
    db_estado = 4'hF;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        db_estado = 4'd0;
      end
      ST_CHECK: begin
        busy      = 1'b1;
        db_estado = 4'd1;
      end
      ST_START: begin
        busy      = 1'b1;
        iniciar   = face_oh;
        db_estado = 4'd2;
      end
      ST_WAIT: begin
        busy      = 1'b1;
        db_estado = 4'd3;
      end
      ST_SETTLE: begin
        busy      = 1'b1;
        db_estado = 4'd4;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        db_estado = 4'd5;
      end
      ST_ERROR: begin
        erro      = 1'b1;
        db_estado = 4'd6;
      end
      default: begin
        db_estado = 4'hF;
      end
    endcase
  end

  assign db_turns_left = turns_q;

endmodule

// File: tb/tb_executor_movimentos.sv
module tb_executor_movimentos;

  localparam int NF  = 6;
  localparam int S   = 4;
  localparam int T   = 20;
  localparam int K   = 10;
  localparam int INI = 0, DON = 1, ERR = 2, NONE = 9;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_face = 3'd0;
  logic [1:0]    cmd_turns = 2'd0;
  logic          cmd_ready;
  logic [NF-1:0] iniciar;
  logic [NF-1:0] pronto = '0;
  logic          busy, done, erro;
  logic          clear_erro = 1'b0;
  logic [3:0]    db_estado;
  logic [1:0]    db_turns_left;

  executor_movimentos #(
    .N_FACES        (NF),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_face      (cmd_face),
    .cmd_turns     (cmd_turns),
    .cmd_ready     (cmd_ready),
    .iniciar       (iniciar),
    .pronto        (pronto),
    .busy          (busy),
    .done          (done),
    .erro          (erro),
    .clear_erro    (clear_erro),
    .db_estado     (db_estado),
    .db_turns_left (db_turns_left)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int kind;
    int c;
    int face;
    int tl;
  } ev_t;
  ev_t exp_q[$];

  task automatic push(input int kind, input int c, input int face, input int tl);
    ev_t e;
    e.kind = kind; e.c = c; e.face = face; e.tl = tl;
    exp_q.push_back(e);
  endtask

  // Reference: command accepted in cycle c0, servo answers k cycles after
  // each start (k<0: never). First start 2 cycles after accept; each turn
  // lasts k+1+S cycles; a reply later than T cycles means timeout.
  task automatic predict(input int c0, input int f, input int n, input int k);
    int s;
    if (f >= NF) begin
      push(ERR, c0 + 2, f, 0);
      return;
    end
    if (n == 0) begin
      push(DON, c0 + 2, f, 0);
      return;
    end
    s = c0 + 2;
    for (int j = 0; j < n; j++) begin
      push(INI, s, f, n - j);
      if (k < 1 || k > T) begin
        push(ERR, s + T + 1, f, 0);
        return;
      end
      s = s + k + 1 + S;
    end
    push(DON, s, f, 0);
  endtask

  // ---------------- servo model ----------------
  int srv_delay = K;
  int srv_cnt   = 0;
  int srv_face  = 0;
  bit srv_noise = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        srv_cnt = 0;
        pronto  = '0;
      end else begin
        pronto = srv_noise ? (NF'($urandom) & ~(NF'(1) << srv_face)) : '0;
        if (srv_cnt > 0) begin
          srv_cnt--;
          if (srv_cnt == 0) pronto[srv_face] = 1'b1;
        end
        if (iniciar != '0) begin
          for (int i = 0; i < NF; i++) if (iniciar[i]) srv_face = i;
          srv_cnt = (srv_delay > 0) ? srv_delay : 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic erro_prev;
    int   kind;
    ev_t  e;
    erro_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        erro_prev = 1'b0;
      end else begin
        chk("status_onehot", {31'd0, $onehot({cmd_ready, busy, erro})}, 1);
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
          e = exp_q.pop_front();
          chk("missed_event", cyc, e.c);
        end
        if (iniciar != '0 || done || (erro && !erro_prev)) begin
          kind = (iniciar != '0) ? INI : (done ? DON : ERR);
          if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, NONE);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.c);
            if (e.kind == INI) begin
              chk("iniciar_vec", {26'd0, iniciar}, 32'd1 << e.face);
              chk("turns_left", {30'd0, db_turns_left}, e.tl);
            end else if (e.kind == DON) begin
              chk("done_turns_left", {30'd0, db_turns_left}, 0);
            end else begin
              chk("erro_ready", {31'd0, cmd_ready}, 0);
            end
          end
        end
        erro_prev = erro;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int f, input int n, input int k);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!cmd_ready && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    chk("ready_before_cmd", {31'd0, cmd_ready}, 1);
    srv_delay = k;
    cmd_valid = 1'b1;
    cmd_face  = 3'(f);
    cmd_turns = 2'(n);
    predict(cyc, f, n, k);
    @(negedge clock);
    // A command presented while busy must be ignored.
    cmd_face  = 3'($urandom);
    cmd_turns = 2'($urandom);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && (cmd_ready || erro)) && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    chk("cmd_completes", {31'd0, guard < 300}, 1);
    if (erro) begin
      cmd_valid = 1'b1;
      cmd_face  = 3'd0;
      cmd_turns = 2'd1;
      repeat (3) begin
        @(negedge clock);
        chk("error_holds", {31'd0, erro}, 1);
        chk("error_not_ready", {31'd0, cmd_ready}, 0);
      end
      cmd_valid  = 1'b0;
      clear_erro = 1'b1;
      @(negedge clock);
      clear_erro = 1'b0;
      chk("clear_erro_low", {31'd0, erro}, 0);
      chk("clear_ready", {31'd0, cmd_ready}, 1);
      chk("clear_state", {28'd0, db_estado}, 0);
    end
  endtask

  task automatic do_reset_now();
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_iniciar", {26'd0, iniciar}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_state", {28'd0, db_estado}, 0);
    chk("rst_turns", {30'd0, db_turns_left}, 0);
    chk("rst_done", {31'd0, done}, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    int f, n, k;
    #1;
    chk("init_ready", {31'd0, cmd_ready}, 1);
    chk("init_busy", {31'd0, busy}, 0);
    chk("init_erro", {31'd0, erro}, 0);
    chk("init_iniciar", {26'd0, iniciar}, 0);
    chk("init_state", {28'd0, db_estado}, 0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("post_rst_ready", {31'd0, cmd_ready}, 1);
    chk("post_rst_done", {31'd0, done}, 0);

    issue(2, 1, K);  finish_cmd();   // single turn
    issue(5, 3, K);  finish_cmd();   // three turns
    issue(6, 1, K);  finish_cmd();   // invalid face
    issue(7, 2, K);  finish_cmd();
    issue(1, 0, K);  finish_cmd();   // no-op move
    issue(0, 1, -1); finish_cmd();   // servo never answers
    issue(0, 1, T);  finish_cmd();   // answer on the timeout cycle
    issue(3, 2, T + 1); finish_cmd(); // one cycle too late
    issue(4, 2, 1);  finish_cmd();   // fastest servo

    // reset while iniciar is high
    issue(2, 2, K);
    chk("start_state", {28'd0, db_estado}, 2);
    do_reset_now();
    repeat (30) @(negedge clock);
    // reset in WAIT during a 2-turn move
    issue(3, 2, K);
    repeat (2) @(negedge clock);
    chk("wait_state", {28'd0, db_estado}, 3);
    do_reset_now();
    repeat (40) @(negedge clock);
    issue(1, 1, K);  finish_cmd();

    srv_noise = 1'b1;
    issue(0, 3, K);  finish_cmd();   // foreign pronto bits ignored
    for (int i = 0; i < 30; i++) begin
      f = $urandom_range(0, 7);
      n = $urandom_range(0, 3);
      k = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, T + 2);
      srv_noise = $urandom_range(0, 1) == 1;
      issue(f, n, k);
      finish_cmd();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    srv_noise = 1'b0;
    repeat (5) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
